// File: rtl/issue_pkg.sv
// Shared types and sizing for the dual-issue scoreboard.
// Define ISSUE_SB_FORWARD_EN to let consumers issue in the producer's final pipe cycle.
package issue_pkg;

  localparam int SB_NUM_REGS = 128;
  localparam int SB_MAX_LAT  = 8;

  function automatic int addr_w_f(input int num_regs);
    return (num_regs > 1) ? $clog2(num_regs) : 1;
  endfunction

  function automatic int lat_w_f(input int max_lat);
    return $clog2(max_lat + 1);
  endfunction

  localparam int SB_ADDR_W = addr_w_f(SB_NUM_REGS);
  localparam int SB_LAT_W  = lat_w_f(SB_MAX_LAT);

`ifdef ISSUE_SB_FORWARD_EN
  localparam int READY_TH = 1;
`else
  localparam int READY_TH = 0;
`endif

  typedef struct packed {
    logic [SB_ADDR_W-1:0] rt;
    logic                 wr;
    logic [SB_ADDR_W-1:0] ra;
    logic [SB_ADDR_W-1:0] rb;
    logic [SB_ADDR_W-1:0] rc;
    logic [2:0]           src_use;
    logic [SB_LAT_W-1:0]  lat;
    logic                 nop;
  } issue_slot_t;

  typedef enum logic {
    PAIR     = 1'b0,
    ODD_ONLY = 1'b1
  } iss_state_e;

endpackage

// File: rtl/sb_counter_bank.sv
// Per-register latency countdown counters with even/odd load ports,
// a source-ready vector and WAW compares for both destination registers.
module sb_counter_bank import issue_pkg::*; #(
  parameter int NUM_REGS = SB_NUM_REGS,
  parameter int ADDR_W   = SB_ADDR_W,
  parameter int LAT_W    = SB_LAT_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                ev_ld_i,
  input  logic [ADDR_W-1:0]   ev_rt_i,
  input  logic [LAT_W-1:0]    ev_lat_i,
  input  logic                od_ld_i,
  input  logic [ADDR_W-1:0]   od_rt_i,
  input  logic [LAT_W-1:0]    od_lat_i,
  output logic [NUM_REGS-1:0] ready_o,
  output logic                ev_waw_ok_o,
  output logic                od_waw_ok_o
);

  localparam logic [LAT_W-1:0] TH = LAT_W'(READY_TH);

  logic [LAT_W-1:0] cnt_q [NUM_REGS];
  logic [LAT_W-1:0] cnt_d [NUM_REGS];

  // A load wins over the decrement; odd is younger so it wins a same-register tie.
  always_comb begin
    for (int i = 0; i < NUM_REGS; i++) begin
      if (od_ld_i && (od_rt_i == ADDR_W'(i))) begin
        cnt_d[i] = od_lat_i;
      end else if (ev_ld_i && (ev_rt_i == ADDR_W'(i))) begin
        cnt_d[i] = ev_lat_i;
      end else if (cnt_q[i] != {LAT_W{1'b0}}) begin
        cnt_d[i] = cnt_q[i] - LAT_W'(1);
      end else begin
        cnt_d[i] = {LAT_W{1'b0}};
      end
      ready_o[i] = (cnt_q[i] <= TH);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= {LAT_W{1'b0}};
      end
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  assign ev_waw_ok_o = (cnt_q[ev_rt_i] <= ev_lat_i);
  assign od_waw_ok_o = (cnt_q[od_rt_i] <= od_lat_i);

endmodule

// File: rtl/issue_scoreboard.sv
// Dual-issue RAW/WAW hazard and in-order issue control for an even/odd pipe pair.
// ISSUE_SB_FORWARD_EN selects the forwarding ready threshold (see issue_pkg).
module issue_scoreboard import issue_pkg::*; #(
  parameter int  NUM_REGS = SB_NUM_REGS,
  parameter int  MAX_LAT  = SB_MAX_LAT,
  parameter int  CNT_W    = 32,
  localparam int ADDR_W   = addr_w_f(NUM_REGS),
  localparam int LAT_W    = lat_w_f(MAX_LAT)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pair_valid,
  output logic              pair_ready,
  input  logic              flush,
  input  logic [ADDR_W-1:0] ev_rt,
  input  logic              ev_wr,
  input  logic [ADDR_W-1:0] ev_ra,
  input  logic [ADDR_W-1:0] ev_rb,
  input  logic [ADDR_W-1:0] ev_rc,
  input  logic [2:0]        ev_use,
  input  logic [LAT_W-1:0]  ev_lat,
  input  logic              ev_nop,
  input  logic [ADDR_W-1:0] od_rt,
  input  logic              od_wr,
  input  logic [ADDR_W-1:0] od_ra,
  input  logic [ADDR_W-1:0] od_rb,
  input  logic [ADDR_W-1:0] od_rc,
  input  logic [2:0]        od_use,
  input  logic [LAT_W-1:0]  od_lat,
  input  logic              od_nop,
  output logic              issue_ev,
  output logic              issue_od,
  output logic [CNT_W-1:0]  stall_cnt
);

  iss_state_e         state_q;
  logic [CNT_W-1:0]   stall_cnt_q;
  logic [CNT_W-1:0]   stall_cnt_d;

  logic [NUM_REGS-1:0] ready_s;
  logic                ev_waw_ok_s;
  logic                od_waw_ok_s;
  logic [LAT_W-1:0]    ev_lat_eff_s;
  logic [LAT_W-1:0]    od_lat_eff_s;
  logic                ev_src_ok_s;
  logic                od_src_ok_s;
  logic                ev_ok_s;
  logic                od_ok_s;
  logic                go_s;
  logic                ev_pending_s;
  logic                od_reads_ev_s;
  logic                intra_haz_s;
  logic                issue_ev_s;
  logic                issue_od_s;

  assign ev_lat_eff_s = (ev_lat == {LAT_W{1'b0}}) ? LAT_W'(1) : ev_lat;
  assign od_lat_eff_s = (od_lat == {LAT_W{1'b0}}) ? LAT_W'(1) : od_lat;

  sb_counter_bank #(
    .NUM_REGS (NUM_REGS),
    .ADDR_W   (ADDR_W),
    .LAT_W    (LAT_W)
  ) u_bank (
    .clk         (clk),
    .reset       (reset),
    .ev_ld_i     (issue_ev_s & ev_wr & ~ev_nop),
    .ev_rt_i     (ev_rt),
    .ev_lat_i    (ev_lat_eff_s),
    .od_ld_i     (issue_od_s & od_wr & ~od_nop),
    .od_rt_i     (od_rt),
    .od_lat_i    (od_lat_eff_s),
    .ready_o     (ready_s),
    .ev_waw_ok_o (ev_waw_ok_s),
    .od_waw_ok_o (od_waw_ok_s)
  );

  assign ev_src_ok_s = (~ev_use[2] | ready_s[ev_ra]) &
                       (~ev_use[1] | ready_s[ev_rb]) &
                       (~ev_use[0] | ready_s[ev_rc]);
  assign od_src_ok_s = (~od_use[2] | ready_s[od_ra]) &
                       (~od_use[1] | ready_s[od_rb]) &
                       (~od_use[0] | ready_s[od_rc]);

  assign ev_ok_s = ev_nop | (ev_src_ok_s & (~ev_wr | ev_waw_ok_s));
  assign od_ok_s = od_nop | (od_src_ok_s & (~od_wr | od_waw_ok_s));

  assign go_s         = pair_valid & ~flush;
  assign ev_pending_s = (state_q == PAIR);
  assign issue_ev_s   = go_s & ev_pending_s & ev_ok_s;

  // Same-cycle dependencies on the even slot cannot be satisfied by the scoreboard yet.
  assign od_reads_ev_s = (od_use[2] & (od_ra == ev_rt)) |
                         (od_use[1] & (od_rb == ev_rt)) |
                         (od_use[0] & (od_rc == ev_rt));
  assign intra_haz_s   = issue_ev_s & ~ev_nop & ~od_nop & ev_wr &
                         (od_reads_ev_s | (od_wr & (od_rt == ev_rt)));

  assign issue_od_s = go_s & (issue_ev_s | ~ev_pending_s) & od_ok_s & ~intra_haz_s;

  assign issue_ev   = issue_ev_s;
  assign issue_od   = issue_od_s;
  assign pair_ready = issue_od_s;
  assign stall_cnt  = stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= PAIR;
    end else if (flush) begin
      state_q <= PAIR;
    end else begin
      case (state_q)
        PAIR: begin
          if (issue_ev_s && !issue_od_s) begin
            state_q <= ODD_ONLY;
          end else begin
            state_q <= PAIR;
          end
        end
        ODD_ONLY: begin
          if (issue_od_s) begin
            state_q <= PAIR;
          end else begin
            state_q <= ODD_ONLY;
          end
        end
        default: state_q <= PAIR;
      endcase
    end
  end

  always_comb begin
    if (pair_valid && !pair_ready && !flush && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= {CNT_W{1'b0}};
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
